// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings, shadow-entry layouts and match helpers for the pipeline hazard controller.
// Forwarding-select encodings match the EX-stage operand muxes in the datapath.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     regwrite;
        logic     memread;
        reg_idx_t dest;
    } dst_info_t;

    // Nothing downstream of WB cares whether the retiring instruction was a load.
    typedef struct packed {
        logic     regwrite;
        reg_idx_t dest;
    } wb_info_t;

    typedef struct packed {
        reg_idx_t rs;
        reg_idx_t rt;
        logic     use_rs;
        logic     use_rt;
    } src_info_t;

    typedef struct packed {
        dst_info_t dst;
        src_info_t src;
    } ex_info_t;

    // $0 is hard-wired, so a write to it can never satisfy a read.
    function automatic logic reg_match(input logic     valid,
                                       input logic     regwrite,
                                       input reg_idx_t dest,
                                       input reg_idx_t src,
                                       input logic     use_src);
        return valid & regwrite & (dest != '0) & (dest == src) & use_src;
    endfunction

    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_EXMEM;
        end
        if (wb_hit) begin
            return FWD_MEMWB;
        end
        return FWD_IDEX;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow-scoreboard entry: a valid bit plus a payload that advances with the pipeline.
// A bubble loads the slot as invalid while still capturing the payload.
module hazard_shadow_stage #(
    parameter int unsigned W = 7
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_load,
    input  logic         i_bubble,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid & ~i_bubble;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stalls, flushes, EX forwarding
// selects and saturating stall/flush counters, driven from a shadow scoreboard of EX/MEM/WB.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit          FORWARD_EN    = 1'b1,
    parameter bit          RF_WRITE_THRU = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [4:0]       id_writereg,
    input  logic             mem_br_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    ex_info_t  w_id_info;
    ex_info_t  w_ex_info;
    dst_info_t w_mem_info;
    wb_info_t  w_wb_next;
    wb_info_t  w_wb_info;
    logic      w_ex_valid;
    logic      w_mem_valid;
    logic      w_wb_valid;

    logic w_ex_hit_rs, w_ex_hit_rt;
    logic w_mem_hit_rs, w_mem_hit_rt;
    logic w_wb_hit_rs, w_wb_hit_rt;
    logic w_load_use;
    logic w_raw_ilk;
    logic w_raw_wb;
    logic w_stall;
    logic w_fa_mem, w_fa_wb, w_fb_mem, w_fb_wb;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_comb begin
        w_id_info.dst.regwrite = id_regwrite;
        w_id_info.dst.memread  = id_memread;
        w_id_info.dst.dest     = id_writereg;
        w_id_info.src.rs       = id_rs;
        w_id_info.src.rt       = id_rt;
        w_id_info.src.use_rs   = id_use_rs;
        w_id_info.src.use_rt   = id_use_rt;
        w_wb_next.regwrite     = w_mem_info.regwrite;
        w_wb_next.dest         = w_mem_info.dest;
    end

    hazard_shadow_stage #(.W($bits(ex_info_t))) u_ex_stage (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_load   (1'b1),
        .i_bubble (w_stall | mem_br_taken),
        .i_valid  (id_valid),
        .i_data   (w_id_info),
        .o_valid  (w_ex_valid),
        .o_data   (w_ex_info)
    );

    hazard_shadow_stage #(.W($bits(dst_info_t))) u_mem_stage (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_load   (1'b1),
        .i_bubble (mem_br_taken),
        .i_valid  (w_ex_valid),
        .i_data   (w_ex_info.dst),
        .o_valid  (w_mem_valid),
        .o_data   (w_mem_info)
    );

    hazard_shadow_stage #(.W($bits(wb_info_t))) u_wb_stage (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_valid  (w_mem_valid),
        .i_data   (w_wb_next),
        .o_valid  (w_wb_valid),
        .o_data   (w_wb_info)
    );

    always_comb begin
        w_ex_hit_rs  = reg_match(w_ex_valid, w_ex_info.dst.regwrite, w_ex_info.dst.dest,
                                 id_rs, id_use_rs);
        w_ex_hit_rt  = reg_match(w_ex_valid, w_ex_info.dst.regwrite, w_ex_info.dst.dest,
                                 id_rt, id_use_rt);
        w_mem_hit_rs = reg_match(w_mem_valid, w_mem_info.regwrite, w_mem_info.dest,
                                 id_rs, id_use_rs);
        w_mem_hit_rt = reg_match(w_mem_valid, w_mem_info.regwrite, w_mem_info.dest,
                                 id_rt, id_use_rt);
        w_wb_hit_rs  = reg_match(w_wb_valid, w_wb_info.regwrite, w_wb_info.dest,
                                 id_rs, id_use_rs);
        w_wb_hit_rt  = reg_match(w_wb_valid, w_wb_info.regwrite, w_wb_info.dest,
                                 id_rt, id_use_rt);

        w_load_use = (w_ex_hit_rs | w_ex_hit_rt) & w_ex_info.dst.memread;
        w_raw_ilk  = 1'b0;
        w_raw_wb   = 1'b0;
        if (!FORWARD_EN) begin
            w_raw_ilk = w_ex_hit_rs | w_ex_hit_rt | w_mem_hit_rs | w_mem_hit_rt;
        end
        if (!RF_WRITE_THRU) begin
            w_raw_wb = w_wb_hit_rs | w_wb_hit_rt;
        end
        // A taken branch flushes the consumer, so its stall is moot.
        w_stall = (w_load_use | w_raw_ilk | w_raw_wb) & id_valid & ~mem_br_taken;
    end

    always_comb begin
        w_fa_mem = w_ex_valid & ~w_mem_info.memread &
                   reg_match(w_mem_valid, w_mem_info.regwrite, w_mem_info.dest,
                             w_ex_info.src.rs, w_ex_info.src.use_rs);
        w_fb_mem = w_ex_valid & ~w_mem_info.memread &
                   reg_match(w_mem_valid, w_mem_info.regwrite, w_mem_info.dest,
                             w_ex_info.src.rt, w_ex_info.src.use_rt);
        w_fa_wb  = w_ex_valid &
                   reg_match(w_wb_valid, w_wb_info.regwrite, w_wb_info.dest,
                             w_ex_info.src.rs, w_ex_info.src.use_rs);
        w_fb_wb  = w_ex_valid &
                   reg_match(w_wb_valid, w_wb_info.regwrite, w_wb_info.dest,
                             w_ex_info.src.rt, w_ex_info.src.use_rt);
        fwd_a_sel = FWD_IDEX;
        fwd_b_sel = FWD_IDEX;
        if (FORWARD_EN) begin
            fwd_a_sel = fwd_pick(w_fa_mem, w_fa_wb);
            fwd_b_sel = fwd_pick(w_fb_mem, w_fb_wb);
        end
    end

    always_comb begin
        pc_write_en   = ~w_stall;
        ifid_write_en = ~w_stall;
        ifid_flush    = mem_br_taken;
        idex_bubble   = w_stall | mem_br_taken;
        exmem_flush   = mem_br_taken;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
            if (mem_br_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CntOne;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
